// File: rtl/hp_pkg.sv
// Shared half-precision datapath definitions: default field widths, bias,
// normalize/round control states and exception-flag bit positions.
package hp_pkg;

  localparam int unsigned NEXP_DEF = 8;
  localparam int unsigned NSIG_DEF = 7;
  localparam int unsigned NGRS_DEF = 3;
  localparam int unsigned BIAS     = (1 << (NEXP_DEF - 1)) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned FLG_ZERO = 0;
  localparam int unsigned FLG_OVF  = 1;
  localparam int unsigned FLG_UNF  = 2;
  localparam int unsigned FLG_INX  = 3;
  localparam int unsigned NFLG     = 4;

endpackage

// File: rtl/hp_rne_round.sv
// Combinational round-to-nearest-even of a normalized (or subnormal)
// significand, producing the packed exponent/fraction fields and flags.
module hp_rne_round
  import hp_pkg::*;
#(
  parameter int unsigned NEXP = NEXP_DEF,
  parameter int unsigned NSIG = NSIG_DEF,
  parameter int unsigned NGRS = NGRS_DEF
) (
  input  logic [NSIG+NGRS+1:0]  i_sig,
  input  logic signed [NEXP+1:0] i_exp,
  output logic [NEXP-1:0]       o_exp_field,
  output logic [NSIG-1:0]       o_frac,
  output logic [NFLG-1:0]       o_flags
);

  localparam int unsigned W = NSIG + NGRS + 2;
  localparam logic signed [NEXP+1:0] EXP_ONE = {{(NEXP+1){1'b0}}, 1'b1};
  localparam logic signed [NEXP+1:0] EXP_MAX = {2'b00, {NEXP{1'b1}}};

  logic                   w_lsb, w_g, w_rs, w_inc;
  logic [NSIG+1:0]        w_m;
  logic [NSIG:0]          w_mn;
  logic signed [NEXP+1:0] w_e;
  logic                   w_ovf;

  assign w_lsb = i_sig[NGRS];
  assign w_g   = i_sig[NGRS-1];
  assign w_rs  = |i_sig[NGRS-2:0];
  assign w_inc = w_g & (w_rs | w_lsb);

  // Top bit of w_m sits at the carry position, so a round-up to 2.0 shows there.
  assign w_m   = i_sig[W-1:NGRS] + {{(NSIG+1){1'b0}}, w_inc};
  assign w_mn  = w_m[NSIG+1] ? w_m[NSIG+1:1] : w_m[NSIG:0];
  assign w_e   = w_m[NSIG+1] ? i_exp + EXP_ONE : i_exp;
  assign w_ovf = (w_e >= EXP_MAX);

  always_comb begin
    o_exp_field = '0;
    o_frac      = '0;
    o_flags     = '0;
    if (w_ovf) begin
      o_exp_field       = '1;
      o_flags[FLG_OVF]  = 1'b1;
      o_flags[FLG_INX]  = 1'b1;
    end else begin
      o_frac           = w_mn[NSIG-1:0];
      o_flags[FLG_INX] = w_g | w_rs;
      if (!w_mn[NSIG]) begin
        o_flags[FLG_UNF]  = w_g | w_rs;
        o_flags[FLG_ZERO] = (w_mn == '0);
      end else begin
        o_exp_field = w_e[NEXP-1:0];
      end
    end
  end

endmodule

// File: rtl/hp_norm_round.sv
// Multi-cycle normalize-and-round stage behind the half-precision adder:
// one left shift per cycle, then RNE, result held over a valid/ready handshake.
module hp_norm_round
  import hp_pkg::*;
#(
  parameter int unsigned NEXP = NEXP_DEF,
  parameter int unsigned NSIG = NSIG_DEF,
  parameter int unsigned NGRS = NGRS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [NEXP-1:0]           in_exp,
  input  logic [NSIG+NGRS+1:0]      in_sig,
  input  logic                      in_special,
  input  logic [NEXP+NSIG:0]        in_special_val,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NEXP+NSIG:0]        out_result,
  output logic                      out_zero,
  output logic                      out_overflow,
  output logic                      out_underflow,
  output logic                      out_inexact
);

  localparam int unsigned W  = NSIG + NGRS + 2;
  localparam int unsigned NR = NEXP + NSIG + 1;
  localparam logic signed [NEXP+1:0] EXP_ONE = {{(NEXP+1){1'b0}}, 1'b1};
  localparam logic signed [NEXP+1:0] EXP_TWO = {{NEXP{1'b0}}, 2'b10};

  state_t                 r_state, w_state_nxt;
  logic                   r_sign;
  logic signed [NEXP+1:0] r_exp;
  logic [W-1:0]           r_sig;
  logic [NR-1:0]          r_result;
  logic [NFLG-1:0]        r_flags;

  logic signed [NEXP+1:0] w_exp_in;
  logic                   w_carry, w_hid_in, w_sig_zero;
  logic [W-1:0]           w_sig_shl;
  logic [NEXP-1:0]        w_exp_field;
  logic [NSIG-1:0]        w_frac;
  logic [NFLG-1:0]        w_flags;

  assign w_exp_in   = (in_exp == '0) ? EXP_ONE : $signed({2'b00, in_exp});
  assign w_carry    = in_sig[W-1];
  assign w_hid_in   = in_sig[W-2];
  assign w_sig_zero = (in_sig == '0);
  assign w_sig_shl  = {r_sig[W-2:0], 1'b0};

  assign in_ready      = (r_state == IDLE);
  assign out_valid     = (r_state == DONE);
  assign out_result    = r_result;
  assign out_zero      = r_flags[FLG_ZERO];
  assign out_overflow  = r_flags[FLG_OVF];
  assign out_underflow = r_flags[FLG_UNF];
  assign out_inexact   = r_flags[FLG_INX];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // The stop test is applied to the value being produced this cycle rather
  // than the held one, so ROUND follows the last shift with no idle check cycle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (in_special || w_sig_zero)                   w_state_nxt = DONE;
          else if (w_carry || w_hid_in || w_exp_in == EXP_ONE) w_state_nxt = ROUND;
          else                                            w_state_nxt = NORM;
        end
      end
      NORM: begin
        if (w_sig_shl[W-2] || r_exp == EXP_TWO) w_state_nxt = ROUND;
      end
      ROUND:   w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_sig    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign <= in_sign;
            if (w_carry) begin
              r_exp <= w_exp_in + EXP_ONE;
              r_sig <= {1'b0, in_sig[W-1:2], |in_sig[1:0]};
            end else begin
              r_exp <= w_exp_in;
              r_sig <= in_sig;
            end
            if (in_special) begin
              r_result <= in_special_val;
              r_flags  <= '0;
            end else if (w_sig_zero) begin
              r_result          <= {in_sign, {(NR-1){1'b0}}};
              r_flags           <= '0;
              r_flags[FLG_ZERO] <= 1'b1;
            end
          end
        end
        NORM: begin
          r_sig <= w_sig_shl;
          r_exp <= r_exp - EXP_ONE;
        end
        ROUND: begin
          r_result <= {r_sign, w_exp_field, w_frac};
          r_flags  <= w_flags;
        end
        default: ;
      endcase
    end
  end

  hp_rne_round #(
    .NEXP (NEXP),
    .NSIG (NSIG),
    .NGRS (NGRS)
  ) u_round (
    .i_sig       (r_sig),
    .i_exp       (r_exp),
    .o_exp_field (w_exp_field),
    .o_frac      (w_frac),
    .o_flags     (w_flags)
  );

endmodule

// File: tb/tb_hp_norm_round.sv
// Self-checking bench for hp_norm_round: directed vector table, randomized
// operands against an arithmetic RNE model, backpressure and mid-op reset.
module tb_hp_norm_round;

  localparam int NEXP = 8;
  localparam int NSIG = 7;
  localparam int NGRS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [11:0] in_sig = '0;
  logic        in_special = 1'b0;
  logic [15:0] in_special_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic        out_zero, out_overflow, out_underflow, out_inexact;

  always #5 clk = ~clk;

  hp_norm_round #(
    .NEXP (NEXP),
    .NSIG (NSIG),
    .NGRS (NGRS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sign        (in_sign),
    .in_exp         (in_exp),
    .in_sig         (in_sig),
    .in_special     (in_special),
    .in_special_val (in_special_val),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_zero       (out_zero),
    .out_overflow   (out_overflow),
    .out_underflow  (out_underflow),
    .out_inexact    (out_inexact)
  );

  int n_checks = 0;
  int n_errors = 0;

  // flags packed as {inexact, underflow, overflow, zero}
  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [11:0] sig;
    logic        spec;
    logic [15:0] sval;
    logic [15:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    int          lat;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Value = sig * 2^(e - bias - 10); pick the result exponent from the MSB
  // position, clamp at 1, and round the integer quotient to nearest even.
  function automatic exp_t model(input logic sign, input int e_in, input int s,
                                 input logic special, input logic [15:0] sval);
    exp_t r;
    int e, p, ee, k, q, rem, half;
    logic inx;
    logic [6:0] qf;
    logic [7:0] ef;
    r.flg = 4'b0000;
    if (special) begin r.res = sval; r.lat = 1; return r; end
    if (s == 0) begin r.res = {sign, 15'b0}; r.flg = 4'b0001; r.lat = 1; return r; end
    e = (e_in == 0) ? 1 : e_in;
    p = 0;
    for (int i = 0; i < 12; i++) if (s[i]) p = i;
    ee = e + p - 10;
    if (ee < 1) ee = 1;
    r.lat = (p == 11) ? 2 : 2 + (e - ee);
    k = 3 + ee - e;
    rem = 0;
    if (k <= 0) q = s << (-k);
    else begin
      q    = s >> k;
      rem  = s & ((1 << k) - 1);
      half = 1 << (k - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    end
    inx = (rem != 0);
    if (q == 256) begin q = 128; ee = ee + 1; end
    qf = q[6:0];
    ef = ee[7:0];
    if (ee >= 255) begin
      r.res = {sign, 8'hFF, 7'h00};
      r.flg = 4'b1010;
    end else if (q < 128) begin
      r.res = {sign, 8'h00, qf};
      r.flg = {inx, inx, 1'b0, (q == 0)};
    end else begin
      r.res = {sign, ef, qf};
      r.flg = {inx, 3'b000};
    end
    return r;
  endfunction

  // Starts and ends on a falling edge; returns when out_valid is first seen.
  task automatic run_op(input logic s, input logic [7:0] e, input logic [11:0] g,
                        input logic sp, input logic [15:0] sv,
                        output logic [15:0] res, output logic [3:0] flg, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!in_ready) check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_sig = g;
    in_special = sp; in_special_val = sv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sign = 1'($urandom); in_exp = 8'($urandom); in_sig = 12'($urandom);
    in_special = 1'($urandom); in_special_val = 16'($urandom);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid) begin lat = c; break; end
    end
    res = out_result;
    flg = {out_inexact, out_underflow, out_overflow, out_zero};
  endtask

  task automatic finish_xfer(input string name);
    @(negedge clk);
    check({name, "_valid_drop"}, out_valid, 0);
    check({name, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[14];
    logic [15:0] res, held_res;
    logic [3:0]  flg, held_flg;
    int          lat, seen;
    exp_t        m;
    logic        r_s, r_sp;
    logic [7:0]  r_e;
    logic [11:0] r_g;
    logic [15:0] r_sv;

    vt[0]  = '{1'b0, 8'd127, 12'h800, 1'b0, 16'h0000, 16'h4000, 4'b0000, 2};
    vt[1]  = '{1'b0, 8'd127, 12'h100, 1'b0, 16'h0000, 16'h3E80, 4'b0000, 4};
    vt[2]  = '{1'b0, 8'd1,   12'h200, 1'b0, 16'h0000, 16'h0040, 4'b0000, 2};
    vt[3]  = '{1'b0, 8'd127, 12'h404, 1'b0, 16'h0000, 16'h3F80, 4'b1000, 2};
    vt[4]  = '{1'b0, 8'd127, 12'h40C, 1'b0, 16'h0000, 16'h3F82, 4'b1000, 2};
    vt[5]  = '{1'b0, 8'd127, 12'h7FC, 1'b0, 16'h0000, 16'h4000, 4'b1000, 2};
    vt[6]  = '{1'b0, 8'd254, 12'h800, 1'b0, 16'h0000, 16'h7F80, 4'b1010, 2};
    vt[7]  = '{1'b0, 8'd0,   12'h000, 1'b1, 16'h7FC0, 16'h7FC0, 4'b0000, 1};
    vt[8]  = '{1'b1, 8'd127, 12'h000, 1'b0, 16'h0000, 16'h8000, 4'b0001, 1};
    vt[9]  = '{1'b0, 8'd11,  12'h001, 1'b0, 16'h0000, 16'h0080, 4'b0000, 12};
    vt[10] = '{1'b0, 8'd1,   12'h3FC, 1'b0, 16'h0000, 16'h0080, 4'b1000, 2};
    vt[11] = '{1'b0, 8'd1,   12'h006, 1'b0, 16'h0000, 16'h0001, 4'b1100, 2};
    vt[12] = '{1'b1, 8'd1,   12'h004, 1'b0, 16'h0000, 16'h8000, 4'b1101, 2};
    vt[13] = '{1'b0, 8'd0,   12'h200, 1'b0, 16'h0000, 16'h0040, 4'b0000, 2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_result", out_result, 0);
    check("reset_flags", {out_inexact, out_underflow, out_overflow, out_zero}, 0);
    check("reset_in_ready", in_ready, 1);

    for (int i = 0; i < 14; i++) begin
      run_op(vt[i].sign, vt[i].exp, vt[i].sig, vt[i].spec, vt[i].sval, res, flg, lat);
      check($sformatf("vec%0d_result", i), res, vt[i].res);
      check($sformatf("vec%0d_flags", i), flg, vt[i].flg);
      check($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      finish_xfer($sformatf("vec%0d", i));
    end

    for (int t = 0; t < 300; t++) begin
      r_s  = 1'($urandom);
      r_e  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r_e = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) r_e = 8'($urandom_range(250, 255));
      r_g  = 12'($urandom & ((1 << $urandom_range(1, 12)) - 1));
      r_sp = ($urandom_range(0, 15) == 0);
      r_sv = 16'($urandom);
      m = model(r_s, int'(r_e), int'(r_g), r_sp, r_sv);
      run_op(r_s, r_e, r_g, r_sp, r_sv, res, flg, lat);
      check($sformatf("rand%0d_result e=%0d sig=%0h", t, r_e, r_g), res, m.res);
      check($sformatf("rand%0d_flags e=%0d sig=%0h", t, r_e, r_g), flg, m.flg);
      check($sformatf("rand%0d_latency e=%0d sig=%0h", t, r_e, r_g), lat, m.lat);
      finish_xfer("rand");
    end

    // Backpressure: result held, no acceptance, single transfer on release.
    out_ready = 1'b0;
    run_op(1'b0, 8'd127, 12'h40C, 1'b0, 16'h0, held_res, held_flg, lat);
    check("bp_result", held_res, 16'h3F82);
    check("bp_flags", held_flg, 4'b1000);
    in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'd200; in_sig = 12'h800; in_special = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_ready", in_ready, 0);
      check("bp_hold_result", out_result, held_res);
      check("bp_hold_flags", {out_inexact, out_underflow, out_overflow, out_zero}, held_flg);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    finish_xfer("bp_release");
    @(negedge clk);
    check("bp_no_ghost", out_valid, 0);
    check("bp_result_after", out_result, held_res);

    // Reset in the middle of normalization abandons the operation.
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd127; in_sig = 12'h100; in_special = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_ready", in_ready, 1);
    check("rst_mid_result", out_result, 0);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_abandoned", seen, 0);
    run_op(1'b0, 8'd127, 12'h400, 1'b0, 16'h0, res, flg, lat);
    check("post_rst_result", res, 16'h3F80);
    check("post_rst_flags", flg, 4'b0000);
    check("post_rst_latency", lat, 2);
    finish_xfer("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
